cal_eep_spi_slave: RTL and testbench
====================================

// Module: cal_eep_spi_slave
// PURPOSE
//  SPI responder modelling the calibration EEPROM that sits behind ss[2] (ss=3'b100) of the command block.
//  Decodes 16-bit write/read frames and holds a 64x8 calibration store.
//  Returns read data on MISO in the low byte of the same frame, so the master's EEP_data is valid at SPI_done.
//  Oversamples SCLK/SS_n/MOSI in the clk domain; no logic runs on SCLK.
// PARAMETERS
//  ADDR_W    6      address bits (depth = 2**ADDR_W)
//  DATA_W    8      data bits per location (frame = 2+ADDR_W+DATA_W = 16)
//  SYNC_STG  2      synchroniser flops on SCLK, SS_n, MOSI (>=2)
//  INIT_VAL  8'hFF  reset contents of every location
// PORTS
//  clk       in   1       system clock; must be >= 8x SCLK rate
//  rst       in   1       asynchronous active-high reset
//  SS_n      in   1       slave select, active low
//  SCLK      in   1       SPI clock, mode 0 (idle low; sample on rise)
//  MOSI      in   1       serial data from master, MSB first
//  MISO      out  1       serial data to master; 0 when not driving
//  wr_done   out  1       1-clk pulse when a write frame commits
//  rd_done   out  1       1-clk pulse when a read frame completes
//  frame_err out  1       1-clk pulse: SS_n rose with bit count != 16
// BEHAVIOUR
//  Frame format, MSB first: [15:14] op, [13:8] addr, [7:0] data.
//    op=01 write; op=00 read; op=1x reserved (frame shifted in, then ignored).
//  Edges: rise/fall detected on the last two synchronised SCLK samples; MOSI taken from the same stage.
//  Latency: 1-cycle detect plus SYNC_STG cycles from pin to event.
//  FSM states and transitions:
//    IDLE  -> SHIFT on synced SS_n falling; clears bit_cnt (5b), shift_in, tx_shift.
//    SHIFT -> on each SCLK rise, shift_in <= {shift_in[14:0],MOSI} and bit_cnt++.
//      When bit_cnt reaches 8 on a rise: latch addr=shift_in[5:0], op=shift_in[7:6].
//      If op=00, load tx_shift <= mem[addr].
//      On SCLK fall with 8<=bit_cnt<16: MISO <= tx_shift[7] and tx_shift shifts left.
//      Thus MISO presents data bit 7 before the 9th rise.
//    SHIFT -> DONE when bit_cnt==16.
//      Further rises before SS_n rises are ignored (no shift, count saturates at 16).
//    DONE  -> IDLE on SS_n rise.
//      Write: mem[addr] <= shift_in[7:0] and wr_done pulses, same cycle as the SS_n rise is detected.
//      Read: rd_done pulses.
//      Reserved op: no pulse, no memory change.
//    SHIFT -> IDLE on SS_n rise with bit_cnt<16: frame_err pulses; no write; memory unchanged.
//  MISO: 0 in IDLE, 0 for op!=00, 0 during bits 15..8; returns to 0 the cycle SS_n rise is seen.
//  Write commits only on SS_n rise, never mid-frame; a read of the same addr in the next frame returns the new value.
//  SCLK edges while SS_n high are ignored.
//  SS_n falling while in DONE (no rise seen): treat as a new frame start; abandon the pending write and pulse frame_err.
//  Reset mid-frame: FSM->IDLE, counters/shift regs cleared, mem[*]<=INIT_VAL, outputs 0; the next frame needs a fresh SS_n fall.
//  Reset values: MISO=0, wr_done=0, rd_done=0, frame_err=0, state=IDLE.
// CONFIGURATION
//  CAL_EEP_WP_EN defined:
//    Adds input port wp (1b, after MOSI) and output wp_hit (1b, after frame_err).
//    Write frame completing with wp=1 (sampled at SS_n rise): memory unchanged, no wr_done, wp_hit pulses 1 clk.
//    Reads are unaffected.
//  CAL_EEP_WP_EN undefined: no wp/wp_hit ports; all complete write frames commit.
// TESTING
//  Reset mid-frame, then fresh read of addr 6'h3F -> MISO shifts 8'hFF; rd_done pulses once.
//  Write frame 16'h4A5C (addr 0x0A, data 0x5C) -> wr_done 1 pulse; then read 16'h0A00 -> MISO bits 7..0 = 0x5C, rd_done pulses.
//  Write 16'h7F81 to addr 0x3F, then read 16'h3F00 -> 0x81; read addr 0x00 still 0xFF (no aliasing/wrap).
//  SS_n raised after 11 bits of 16'h4A11 -> frame_err pulse, no wr_done; read of addr 0x0A returns prior value.
//  Reserved frame 16'hC0AA, then 20 SCLK pulses with SS_n high -> no pulses, MISO stays 0, memory unchanged.
//  (CAL_EEP_WP_EN) wp=1, write 16'h4233 -> wp_hit pulse; read of addr 0x02 returns 0xFF; wp=0 retry -> 0x33.

Source files
------------

// File: rtl/cal_eep_spi_if.sv
// cal_eep_spi_if: SPI pins and completion strobes between the command block (master) and the calibration EEPROM (slave)
//  SS_n/SCLK/MOSI come from the master. MISO, wr_done, rd_done and frame_err come back from the slave.
//  With CAL_EEP_WP_EN defined, the interface also carries wp (master -> slave) and wp_hit (slave -> master).
interface cal_eep_spi_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic wr_done;
  logic rd_done;
  logic frame_err;
`ifdef CAL_EEP_WP_EN
  logic wp;
  logic wp_hit;
  modport master(output SS_n, SCLK, MOSI, wp, input MISO, wr_done, rd_done, frame_err, wp_hit);
  modport slave(input SS_n, SCLK, MOSI, wp, output MISO, wr_done, rd_done, frame_err, wp_hit);
`else
  modport master(output SS_n, SCLK, MOSI, input MISO, wr_done, rd_done, frame_err);
  modport slave(input SS_n, SCLK, MOSI, output MISO, wr_done, rd_done, frame_err);
`endif
endinterface

// File: rtl/cal_eep_spi_slave.sv
// cal_eep_spi_slave: SPI-attached 64x8 calibration EEPROM model that oversamples the SPI pins in the clk domain
//  Ports: clk (system clock, >= 8x SCLK), rst (async active-high reset),
//         bus (cal_eep_spi_if.slave: SS_n, SCLK, MOSI in; MISO, wr_done, rd_done, frame_err out)
//  Frame, MSB first: [15:14] op (01 write, 00 read, 1x reserved), [13:8] addr, [7:0] data.
//  Read data is returned on MISO during the low byte of the same frame.
//  Optional: define CAL_EEP_WP_EN to add write protect (bus.wp in, bus.wp_hit out).
module cal_eep_spi_slave #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int SYNC_STG = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = 8'hFF
) (
  input logic clk,
  input logic rst,
  cal_eep_spi_if.slave bus
);
  localparam int FW = 2 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FW + 1);
  localparam int DEPTH = 1 << ADDR_W;
  // Only the most recent header-or-data-sized window of the frame is ever read back.
  localparam int SW = (DATA_W > 2 + ADDR_W) ? DATA_W : 2 + ADDR_W;
  localparam logic [CW-1:0] HDR_CNT = CW'(2 + ADDR_W);
  localparam logic [CW-1:0] FW_CNT = CW'(FW);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STG:0] sclk_q, ss_q;
  logic [SYNC_STG-1:0] mosi_q;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s, wp_s;
  logic [CW-1:0] bit_cnt, cnt_inc;
  logic [SW-1:0] shift_in, shift_nxt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [1:0] op;
  logic miso, wr_done, rd_done, frame_err;
  logic start, shift, tx_step, fin, err, do_wr, do_rd;
  // SS_n history resets low so that a select held low across reset never looks like a fresh fall;
  // a pin that is actually high just produces a rise, which IDLE ignores.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q <= '0;
      ss_q <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STG-1:0], bus.SCLK};
      ss_q <= {ss_q[SYNC_STG-1:0], bus.SS_n};
      mosi_q <= {mosi_q[SYNC_STG-2:0], bus.MOSI};
    end
  assign sclk_rise = sclk_q[SYNC_STG-1] & ~sclk_q[SYNC_STG];
  assign sclk_fall = ~sclk_q[SYNC_STG-1] & sclk_q[SYNC_STG];
  assign ss_rise = ss_q[SYNC_STG-1] & ~ss_q[SYNC_STG];
  assign ss_fall = ~ss_q[SYNC_STG-1] & ss_q[SYNC_STG];
  assign mosi_s = mosi_q[SYNC_STG-1];
  assign cnt_inc = bit_cnt + 1'b1;
  assign shift_nxt = {shift_in[SW-2:0], mosi_s};
`ifdef CAL_EEP_WP_EN
  logic [SYNC_STG-1:0] wp_q;
  logic wp_hit;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      wp_hit <= 1'b0;
    end else begin
      wp_q <= {wp_q[SYNC_STG-2:0], bus.wp};
      wp_hit <= fin && op == 2'b01 && wp_s;
    end
  assign wp_s = wp_q[SYNC_STG-1];
  assign bus.wp_hit = wp_hit;
`else
  assign wp_s = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = ss_fall ? SHIFT : IDLE;
      SHIFT: state_nxt = ss_rise ? IDLE : (shift && cnt_inc == FW_CNT) ? DONE : SHIFT;
      DONE: state_nxt = ss_rise ? IDLE : ss_fall ? SHIFT : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // A fall seen in DONE (no rise in between) restarts the frame and drops the pending write.
  always_comb begin
    start = ss_fall && state != SHIFT;
    shift = state == SHIFT && sclk_rise && !ss_rise;
    tx_step = state == SHIFT && sclk_fall && !ss_rise && bit_cnt >= HDR_CNT;
    fin = state == DONE && ss_rise;
    err = (state == SHIFT && ss_rise) || (state == DONE && ss_fall);
    do_wr = fin && op == 2'b01 && !wp_s;
    do_rd = fin && op == 2'b00;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bit_cnt <= '0;
      shift_in <= '0;
      tx_shift <= '0;
      addr <= '0;
      op <= '0;
      miso <= 1'b0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else begin
      wr_done <= do_wr;
      rd_done <= do_rd;
      frame_err <= err;
      miso <= (start || ss_rise || state == IDLE) ? 1'b0 : tx_step ? tx_shift[DATA_W-1] : miso;
      if (start) begin
        bit_cnt <= '0;
        shift_in <= '0;
        tx_shift <= '0;
      end else if (shift) begin
        bit_cnt <= cnt_inc;
        shift_in <= shift_nxt;
        // Header complete: latch it and, for a read, fetch the byte so it can leave on the next fall.
        if (cnt_inc == HDR_CNT) begin
          addr <= shift_nxt[ADDR_W-1:0];
          op <= shift_nxt[ADDR_W+1:ADDR_W];
          if (shift_nxt[ADDR_W+1:ADDR_W] == 2'b00) tx_shift <= mem[shift_nxt[ADDR_W-1:0]];
        end
      end else if (tx_step) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      if (do_wr) mem[addr] <= shift_in[DATA_W-1:0];
    end
  assign bus.MISO = miso;
  assign bus.wr_done = wr_done;
  assign bus.rd_done = rd_done;
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_cal_eep_spi_slave.sv
// tb_cal_eep_spi_slave: self-checking bench for cal_eep_spi_slave (vector table, corner sequences, random frames vs. frame-level model)
module tb_cal_eep_spi_slave;
  localparam int HALF = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cal_eep_spi_if bus();
  cal_eep_spi_slave dut (.clk(clk), .rst(rst), .bus(bus));
  int n_checks = 0;
  int n_fail = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_miso = 0, n_wp = 0;
  logic [7:0] ref_mem [64];
  typedef struct {
    logic [15:0] f;
    int n;
    logic [15:0] rx;
    int wr;
    int rd;
    int err;
  } vec_t;
  vec_t vecs[8];
  always @(posedge clk) begin
    if (bus.wr_done) n_wr++;
    if (bus.rd_done) n_rd++;
    if (bus.frame_err) n_err++;
    if (bus.MISO) n_miso++;
`ifdef CAL_EEP_WP_EN
    if (bus.wp_hit) n_wp++;
`endif
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_clk(input int k);
    repeat (k) @(negedge clk);
  endtask
  // Master side of mode 0: MOSI changes after each fall, MISO is sampled just before each rise.
  task automatic shift_bits(input logic [15:0] f, input int n, output logic [15:0] rx);
    rx = '0;
    bus.SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < n; i++) begin
      bus.MOSI = f[15-i];
      wait_clk(HALF);
      rx[15-i] = bus.MISO;
      bus.SCLK = 1'b1;
      wait_clk(HALF);
      bus.SCLK = 1'b0;
    end
  endtask
  task automatic run_frame(input logic [15:0] f, input int n, output logic [15:0] rx,
                           output int dwr, output int drd, output int derr);
    int w0, r0, e0;
    w0 = n_wr;
    r0 = n_rd;
    e0 = n_err;
    shift_bits(f, n, rx);
    wait_clk(HALF);
    bus.SS_n = 1'b1;
    wait_clk(12);
    dwr = n_wr - w0;
    drd = n_rd - r0;
    derr = n_err - e0;
  endtask
  // Frame-level reference: what the master should see and which strobe should fire.
  task automatic model_frame(input logic [15:0] f, input int n, output logic [15:0] rx,
                             output int wr, output int rd, output int err);
    logic [15:0] mask, full;
    logic [1:0] op;
    logic [5:0] a;
    op = f[15:14];
    a = f[13:8];
    full = (op == 2'b00) ? {8'h00, ref_mem[a]} : 16'h0000;
    mask = 16'hFFFF;
    mask = mask << (16 - n);
    rx = full & mask;
    wr = (n == 16 && op == 2'b01) ? 1 : 0;
    rd = (n == 16 && op == 2'b00) ? 1 : 0;
    err = (n != 16) ? 1 : 0;
    if (wr == 1) ref_mem[a] = f[7:0];
  endtask
  initial begin
    logic [15:0] rx, erx, f;
    int dwr, drd, derr, ewr, erd, eerr, e0, m0, n;
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
`ifdef CAL_EEP_WP_EN
    bus.wp = 1'b0;
`endif
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'hFF;
    vecs[0] = '{16'h4A5C, 16, 16'h0000, 1, 0, 0};
    vecs[1] = '{16'h0A00, 16, 16'h005C, 0, 1, 0};
    vecs[2] = '{16'h7F81, 16, 16'h0000, 1, 0, 0};
    vecs[3] = '{16'h3F00, 16, 16'h0081, 0, 1, 0};
    vecs[4] = '{16'h0000, 16, 16'h00FF, 0, 1, 0};
    vecs[5] = '{16'h4A11, 11, 16'h0000, 0, 0, 1};
    vecs[6] = '{16'h0A00, 16, 16'h005C, 0, 1, 0};
    vecs[7] = '{16'hC0AA, 16, 16'h0000, 0, 0, 0};
    wait_clk(4);
    check("reset_outputs_in_rst", {28'd0, bus.MISO, bus.wr_done, bus.rd_done, bus.frame_err}, 32'd0);
    rst = 1'b0;
    wait_clk(6);
    check("reset_outputs_after_rst", {28'd0, bus.MISO, bus.wr_done, bus.rd_done, bus.frame_err}, 32'd0);
    run_frame(16'h7F12, 16, rx, dwr, drd, derr);
    check("pre_reset_write_wr", dwr, 1);
    shift_bits(16'h3F00, 5, rx);
    rst = 1'b1;
    wait_clk(3);
    check("midframe_rst_outputs", {28'd0, bus.MISO, bus.wr_done, bus.rd_done, bus.frame_err}, 32'd0);
    rst = 1'b0;
    e0 = n_err;
    wait_clk(HALF);
    bus.SS_n = 1'b1;
    wait_clk(12);
    check("post_rst_ss_rise_no_err", n_err - e0, 0);
    run_frame(16'h3F00, 16, rx, dwr, drd, derr);
    check("post_rst_read3f_rx", rx, 16'h00FF);
    check("post_rst_read3f_rd", drd, 1);
    check("post_rst_read3f_err", derr, 0);
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].f, vecs[i].n, rx, dwr, drd, derr);
      check($sformatf("vec%0d_rx", i), rx, vecs[i].rx);
      check($sformatf("vec%0d_wr", i), dwr, vecs[i].wr);
      check($sformatf("vec%0d_rd", i), drd, vecs[i].rd);
      check($sformatf("vec%0d_err", i), derr, vecs[i].err);
      check($sformatf("vec%0d_miso_idle", i), bus.MISO, 1'b0);
      model_frame(vecs[i].f, vecs[i].n, erx, ewr, erd, eerr);
    end
    m0 = n_miso;
    e0 = n_wr + n_rd + n_err;
    for (int i = 0; i < 20; i++) begin
      bus.MOSI = 1'($urandom);
      bus.SCLK = 1'b1;
      wait_clk(HALF);
      bus.SCLK = 1'b0;
      wait_clk(HALF);
    end
    wait_clk(12);
    check("sclk_ss_high_miso", n_miso - m0, 0);
    check("sclk_ss_high_pulses", n_wr + n_rd + n_err - e0, 0);
    run_frame(16'h0A00, 16, rx, dwr, drd, derr);
    check("after_reserved_read0a", rx, 16'h005C);
    run_frame(16'h0000, 16, rx, dwr, drd, derr);
    check("after_reserved_read00", rx, 16'h00FF);
`ifdef CAL_EEP_WP_EN
    bus.wp = 1'b1;
    e0 = n_wp;
    run_frame(16'h4233, 16, rx, dwr, drd, derr);
    check("wp_write_wr", dwr, 0);
    check("wp_write_hit", n_wp - e0, 1);
    bus.wp = 1'b0;
    run_frame(16'h0200, 16, rx, dwr, drd, derr);
    check("wp_read02", rx, 16'h00FF);
    run_frame(16'h4233, 16, rx, dwr, drd, derr);
    check("wp_retry_wr", dwr, 1);
    run_frame(16'h0200, 16, rx, dwr, drd, derr);
    check("wp_retry_read02", rx, 16'h0033);
    ref_mem[2] = 8'h33;
`endif
    for (int i = 0; i < 40; i++) begin
      f[15:14] = 2'($urandom_range(0, 3));
      f[13:8] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      f[7:0] = 8'($urandom);
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
      model_frame(f, n, erx, ewr, erd, eerr);
      run_frame(f, n, rx, dwr, drd, derr);
      check($sformatf("rnd%0d_rx f=%h n=%0d", i, f, n), rx, erx);
      check($sformatf("rnd%0d_pulses f=%h n=%0d", i, f, n), {8'd0, 8'(dwr), 8'(drd), 8'(derr)},
            {8'd0, 8'(ewr), 8'(erd), 8'(eerr)});
      check($sformatf("rnd%0d_miso_idle", i), bus.MISO, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
